// File: rtl/apb_ic_master_mux_pkg.sv
// Shared types and defaults for the APB master-side multiplexer.
// The optional ACCESS timeout is enabled with the APB_IC_TIMEOUT_EN macro.
package apb_ic_master_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_ADDR_WIDTH  = 16;
    localparam int DEF_DATA_WIDTH  = 16;

    // Timeout counter is never narrower than 8 bits.
    function automatic int cnt_width(input int max_count);
        int w;
        w = $clog2(max_count + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/apb_ic_master_mux_if.sv
// Bundle of master-side, slave-side and arbiter signals around the multiplexer.
// The 'master' modport is the multiplexer's view; 'slave' is the environment's view.
interface apb_ic_master_mux_if
    import apb_ic_master_mux_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
);
    // Handshake: a master starts with psel=1/penable=0 while granted and holds its
    // request stable until its m_pready bit pulses for one cycle; the slave side
    // completes an ACCESS cycle when s_psel && s_penable && s_pready.
    logic [NUM_MASTERS-1:0]            grants;
    logic [NUM_MASTERS-1:0]            reqs;
    logic [NUM_MASTERS-1:0]            m_psel;
    logic [NUM_MASTERS-1:0]            m_penable;
    logic [NUM_MASTERS-1:0]            m_pwrite;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_paddr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_pwdata;
    logic [DATA_WIDTH-1:0]             m_prdata;
    logic [NUM_MASTERS-1:0]            m_pready;
    logic                              m_pslverr;
    logic                              s_psel;
    logic                              s_penable;
    logic                              s_pwrite;
    logic [ADDR_WIDTH-1:0]             s_paddr;
    logic [DATA_WIDTH-1:0]             s_pwdata;
    logic [DATA_WIDTH-1:0]             s_prdata;
    logic                              s_pready;
    state_t                            state;

    modport master (
        input  grants, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, s_prdata, s_pready,
        output reqs, m_prdata, m_pready, m_pslverr,
        output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, state
    );

    modport slave (
        output grants, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, s_prdata, s_pready,
        input  reqs, m_prdata, m_pready, m_pslverr,
        input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, state
    );

endinterface

// File: rtl/apb_ic_master_mux_onehot_enc.sv
// One-hot (or multi-hot) grant vector to index; the lowest set bit wins.
module apb_ic_master_mux_onehot_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  onehot,
    output logic [IW-1:0] index,
    output logic          valid
);

    always_comb begin
        index = '0;
        valid = 1'b0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                index = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_ic_master_mux.sv
// Replays the granted master's APB transfer onto the shared slave bus and returns the response to it.
// Define APB_IC_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES with m_pslverr=1.
module apb_ic_master_mux
    import apb_ic_master_mux_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
`ifdef APB_IC_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input logic                 clk,
    input logic                 reset,
    apb_ic_master_mux_if.master bus
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    state_t                 state;
    logic [IW-1:0]          grant_idx;
    logic                   grant_valid;
    logic                   start;
    logic                   abort;
    logic [IW-1:0]          owner;
    logic [ADDR_WIDTH-1:0]  paddr_q;
    logic [DATA_WIDTH-1:0]  pwdata_q;
    logic [DATA_WIDTH-1:0]  prdata_q;
    logic                   pwrite_q;
    logic                   psel_q;
    logic                   penable_q;
    logic [NUM_MASTERS-1:0] pready_q;

    apb_ic_master_mux_onehot_enc #(.N(NUM_MASTERS), .IW(IW)) u_enc (
        .onehot (bus.grants),
        .index  (grant_idx),
        .valid  (grant_valid)
    );

    assign bus.reqs = bus.m_psel;
    // Only a fresh SETUP phase from the granted master starts a transfer.
    assign start = grant_valid && bus.m_psel[grant_idx] && !bus.m_penable[grant_idx];

`ifdef APB_IC_TIMEOUT_EN
    localparam int CW = cnt_width(TIMEOUT_CYCLES);
    logic [CW-1:0] tmo_cnt;
    logic          aborted;
    logic          pslverr_q;

    assign abort = (state == ST_ACCESS) && (tmo_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt   <= '0;
            aborted   <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            pslverr_q <= (state == ST_DONE) && aborted;
            if (state == ST_SETUP) begin
                tmo_cnt <= '0;
                aborted <= 1'b0;
            end else if (state == ST_ACCESS && !abort) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else if (abort && !bus.s_pready) begin
                aborted <= 1'b1;
            end
        end
    end

    assign bus.m_pslverr = pslverr_q;
`else
    assign abort         = 1'b0;
    assign bus.m_pslverr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            owner     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            prdata_q  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pready_q  <= '0;
        end else begin
            pready_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        owner    <= grant_idx;
                        paddr_q  <= bus.m_paddr[grant_idx * ADDR_WIDTH +: ADDR_WIDTH];
                        pwdata_q <= bus.m_pwdata[grant_idx * DATA_WIDTH +: DATA_WIDTH];
                        pwrite_q <= bus.m_pwrite[grant_idx];
                        psel_q   <= 1'b1;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (bus.s_pready) begin
                        prdata_q  <= bus.s_prdata;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state     <= ST_DONE;
                    end else if (abort) begin
                        prdata_q  <= '0;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    pready_q <= NUM_MASTERS'(1) << owner;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_psel    = psel_q;
    assign bus.s_penable = penable_q;
    assign bus.s_pwrite  = pwrite_q;
    assign bus.s_paddr   = paddr_q;
    assign bus.s_pwdata  = pwdata_q;
    assign bus.m_prdata  = prdata_q;
    assign bus.m_pready  = pready_q;
    assign bus.state     = state;

endmodule

// File: tb/tb_apb_ic_master_mux.sv
// Scoreboard bench for apb_ic_master_mux: random and directed transfers, slave wait states, reset abort.
module tb_apb_ic_master_mux;
    import apb_ic_master_mux_pkg::*;

    localparam int NM = 4;
    localparam int AW = 16;
    localparam int DW = 16;
`ifdef APB_IC_TIMEOUT_EN
    localparam int TO = 8;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // {pready_cycle[52:21], pready[20:17], prdata[16:1], pslverr[0]}
    logic [52:0] exp_q[$];
    // {addr[32:17], write[16], wdata[15:0]} seen on a completing slave ACCESS
    logic [32:0] slv_q[$];
    // {waits[23:16], rdata[15:0]}; waits 8'hFF means the slave never answers
    logic [23:0] rsp_q[$];

    apb_ic_master_mux_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_ic_master_mux #(
        .NUM_MASTERS (NM),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW)
`ifdef APB_IC_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int owner_of(input logic [3:0] g);
        for (int i = 0; i < NM; i++)
            if (g[i]) return i;
        return 0;
    endfunction

    // Drives the granted master's request and records what the model predicts:
    // lowest grant bit owns the bus, response arrives 3 + waits cycles after accept.
    task automatic issue(input logic [3:0] g, input bit wr, input logic [15:0] a,
                         input logic [15:0] d, input int w, input logic [15:0] rd,
                         input int acc);
        int m;
        m = owner_of(g);
        bus.grants            = g;
        bus.m_psel[m]         = 1'b1;
        bus.m_penable[m]      = 1'b0;
        bus.m_pwrite[m]       = wr;
        bus.m_paddr[m*AW +: AW]  = a;
        bus.m_pwdata[m*DW +: DW] = d;
        rsp_q.push_back({8'(w), rd});
        slv_q.push_back({a, wr, d});
        exp_q.push_back({32'(acc + 3 + w), 4'(1 << m), rd, 1'b0});
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
            slv_q.delete();
            rsp_q.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m_pready"},  32'(bus.m_pready), 32'h0);
        chk({tag, "_m_prdata"},  32'(bus.m_prdata), 32'h0);
        chk({tag, "_m_pslverr"}, 32'(bus.m_pslverr), 32'h0);
        chk({tag, "_s_psel"},    32'(bus.s_psel), 32'h0);
        chk({tag, "_s_penable"}, 32'(bus.s_penable), 32'h0);
        chk({tag, "_s_pwrite"},  32'(bus.s_pwrite), 32'h0);
        chk({tag, "_s_paddr"},   32'(bus.s_paddr), 32'h0);
        chk({tag, "_s_pwdata"},  32'(bus.s_pwdata), 32'h0);
        chk({tag, "_state"},     32'(bus.state), 32'(ST_IDLE));
        chk({tag, "_reqs"},      32'(bus.reqs), 32'(bus.m_psel));
    endtask

    // slave responder: answers each ACCESS phase from rsp_q
    int          wcnt = 0;
    bit          in_acc = 1'b0;
    logic [23:0] cur = '0;
    always @(negedge clk) begin
        if (bus.s_psel && bus.s_penable) begin
            if (!in_acc) begin
                in_acc = 1'b1;
                wcnt   = 0;
                cur    = (rsp_q.size() > 0) ? rsp_q.pop_front() : 24'h0;
            end
            if (cur[23:16] != 8'hFF && wcnt == int'(cur[23:16])) begin
                bus.s_pready = 1'b1;
                bus.s_prdata = cur[15:0];
            end else begin
                bus.s_pready = 1'b0;
                bus.s_prdata = 16'($urandom);
            end
            wcnt++;
        end else begin
            in_acc       = 1'b0;
            bus.s_pready = 1'b0;
            bus.s_prdata = 16'($urandom);
        end
    end

    // monitor: compares slave-side and master-side responses against the queues
    logic [52:0] e;
    logic [32:0] s;
    always @(negedge clk) begin
        #1;
        if (reset) begin
            chk("reqs", 32'(bus.reqs), 32'(bus.m_psel));
            if (bus.s_psel && bus.s_penable && bus.s_pready) begin
                if (slv_q.size() == 0) begin
                    chk("slave_unexpected_access", 32'(bus.s_paddr), 32'hFFFF_FFFF);
                end else begin
                    s = slv_q.pop_front();
                    chk("s_paddr",  32'(bus.s_paddr), 32'(s[32:17]));
                    chk("s_pwrite", 32'(bus.s_pwrite), 32'(s[16]));
                    chk("s_pwdata", 32'(bus.s_pwdata), 32'(s[15:0]));
                end
            end
            if (bus.m_pready != '0) begin
                if (exp_q.size() == 0) begin
                    chk("m_pready_unexpected", 32'(bus.m_pready), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_pready",   32'(bus.m_pready), 32'(e[20:17]));
                    chk("m_prdata",   32'(bus.m_prdata), 32'(e[16:1]));
                    chk("m_pslverr",  32'(bus.m_pslverr), 32'(e[0]));
                    chk("pready_cycle", 32'(cyc), e[52:21]);
                end
                for (int i = 0; i < NM; i++) begin
                    if (bus.m_pready[i]) begin
                        bus.m_psel[i]    = 1'b0;
                        bus.m_penable[i] = 1'b0;
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        int c1;
        logic [3:0] g;
        bus.grants    = '0;
        bus.m_psel    = '0;
        bus.m_penable = '0;
        bus.m_pwrite  = '0;
        bus.m_paddr   = '0;
        bus.m_pwdata  = '0;

        // reset held low for 5 cycles; reqs keeps following m_psel
        repeat (5) begin
            @(negedge clk);
            bus.m_psel = 4'($urandom_range(0, 15));
            #1 chk_reset_outputs("reset");
        end
        @(negedge clk);
        bus.m_psel = '0;
        reset = 1'b1;
        @(negedge clk);

        // m0 zero-wait write
        issue(4'b0001, 1'b1, 16'h0010, 16'hBEEF, 0, 16'h0000, cyc + 1);
        wait_drain(40);

        // m2 read with 4 wait states
        issue(4'b0100, 1'b0, 16'h0200, 16'h0000, 4, 16'h1234, cyc + 1);
        wait_drain(40);

        // grant moves to m2 while m1 is in ACCESS; m2 follows right after m1 completes
        issue(4'b0010, 1'b1, 16'h0111, 16'hAAAA, 3, 16'h0F0F, cyc + 1);
        c1 = cyc + 1 + 3 + 3;
        repeat (3) @(negedge clk);
        issue(4'b0100, 1'b0, 16'h0222, 16'h5555, 1, 16'hC0DE, c1 + 1);
        wait_drain(60);

        // two grant bits: m1 wins; m2 also requests with a different address
        bus.m_psel[2] = 1'b1;
        bus.m_paddr[2*AW +: AW] = 16'hDEAD;
        issue(4'b0110, 1'b0, 16'h0333, 16'h0000, 2, 16'h7777, cyc + 1);
        wait_drain(40);
        bus.m_psel[2] = 1'b0;
        bus.grants = '0;

        // granted master already in its enable phase, then no grant at all: no start
        @(negedge clk);
        bus.grants = 4'b0001;
        bus.m_psel[0] = 1'b1;
        bus.m_penable[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #2 chk("no_start_penable", 32'(bus.s_psel), 32'h0);
        end
        bus.grants = 4'b0000;
        bus.m_penable[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #2 chk("no_start_nogrant", 32'(bus.s_psel), 32'h0);
        end
        bus.m_psel = '0;
        @(negedge clk);

        // reset in ACCESS drops the transfer without a pready pulse
        issue(4'b0001, 1'b0, 16'h0444, 16'h0000, 10, 16'h9999, cyc + 1);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        slv_q.delete();
        rsp_q.delete();
        repeat (2) @(negedge clk);
        #2 chk_reset_outputs("reset_access");
        bus.m_psel = '0;
        bus.grants = '0;
        reset = 1'b1;
        repeat (15) begin
            @(negedge clk);
            #2 chk("no_pready_after_reset", 32'(bus.m_pready), 32'h0);
        end

        // random transfers
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            g = 4'($urandom_range(1, 15));
            issue(g, 1'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 5), 16'($urandom), cyc + 1);
            wait_drain(40);
        end

`ifdef APB_IC_TIMEOUT_EN
        // slave never ready: abort with error and zero data
        @(negedge clk);
        bus.grants = 4'b0001;
        bus.m_psel[0] = 1'b1;
        bus.m_penable[0] = 1'b0;
        bus.m_paddr[0 +: AW] = 16'h0555;
        rsp_q.push_back({8'hFF, 16'h5A5A});
        exp_q.push_back({32'(cyc + 1 + 3 + TO), 4'b0001, 16'h0000, 1'b1});
        wait_drain(TO + 40);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
